matrix_loader: RTL and testbench

- Downstream consumer of the matrix file reader.
- Accepts the reader's raster-order element stream (value, i, j) over the value_stb/value_ack handshake and stores it into an n x n on-chip buffer.
- Exposes a registered random-access read port to the multiplier datapath.
- Signals completion with a one-cycle done pulse and a sticky full flag.

---
 rtl/matrix_loader.sv | 171 +++++++++++++++++
 tb/tb_matrix_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// matrix_loader: captures a raster-order stream of n x n 32-bit words from the
// matrix file reader into an on-chip buffer and serves a registered,
// one-cycle-latency random-access read port to the multiplier datapath.
// Optional build feature: define MATRIX_LOADER_ORDER_CHECK_EN to compare the
// reader's (i, j) against the internal write counters and raise a sticky err.
//
// Handshake: the reader holds value_stb with value/i/j stable until it sees
// value_ack; value_ack is high for exactly one cycle per captured element and
// the reader drops value_stb on the edge it samples that ack, so an element is
// never captured twice. The write address always comes from the internal
// (r, c) counters, never from the incoming i/j.
module matrix_loader #(
  parameter  int n = 8,
  localparam int W = (n > 1) ? $clog2(n) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          value_stb,
  input  logic [31:0]   value,
  input  logic [W-1:0]  i,
  input  logic [W-1:0]  j,
  output logic          value_ack,
  input  logic [W-1:0]  rd_row,
  input  logic [W-1:0]  rd_col,
  output logic [31:0]   rd_data,
  output logic          busy,
  output logic          full,
  output logic          done,
  output logic          err,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [W-1:0] LAST = W'(n - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  c_q, c_d;
  logic          ack_q, ack_d;
  logic          full_q, full_d;
  logic          done_q, done_d;
  logic          we;
  logic          rd_in_range;
  logic [31:0]   rd_data_q, rd_data_d;

  // Buffer contents are deliberately not reset.
  logic [31:0]   mem_q [0:n-1][0:n-1];

`ifdef MATRIX_LOADER_ORDER_CHECK_EN
  logic          err_q, err_d;
  logic          order_bad;
  assign order_bad = (i != r_q) || (j != c_q);
`else
  logic          unused_idx;
  assign unused_idx = ^{i, j};
`endif

  // Next-state, counter and flag logic for the load FSM.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    ack_d   = 1'b0;
    full_d  = full_q;
    done_d  = 1'b0;
    we      = 1'b0;
`ifdef MATRIX_LOADER_ORDER_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = '0;
          c_d     = '0;
          full_d  = 1'b0;
`ifdef MATRIX_LOADER_ORDER_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (value_stb && !ack_q) begin
          we      = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
`ifdef MATRIX_LOADER_ORDER_CHECK_EN
          if (order_bad) err_d = 1'b1;
`endif
        end
      end
      ACK: begin
        if ((r_q == LAST) && (c_q == LAST)) begin
          state_d = DONE;
        end else if (c_q == LAST) begin
          c_d     = '0;
          r_d     = r_q + 1'b1;
          state_d = LOAD;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        full_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range read addresses (only possible for non-power-of-2 n) return 0.
  always_comb begin
    rd_in_range = ({1'b0, rd_row} < (W+1)'(n)) && ({1'b0, rd_col} < (W+1)'(n));
    rd_data_d   = '0;
    if (rd_in_range) rd_data_d = mem_q[rd_row][rd_col];
  end

  // Control state and registered read data, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      c_q       <= '0;
      ack_q     <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      ack_q     <= ack_d;
      full_q    <= full_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

`ifdef MATRIX_LOADER_ORDER_CHECK_EN
  // Sticky order-mismatch flag, cleared by start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Buffer write; a same-cycle read of this address still sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[r_q][c_q] <= value;
  end

  assign value_ack = ack_q;
  assign busy      = (state_q != IDLE);
  assign full      = full_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Testbench for matrix_loader: a reader model streams directed matrices,
// read-port expectations go into a queue and a monitor compares rd_data when
// it becomes valid; a second n=2 instance covers the smallest build.
module tb_matrix_loader;

  localparam int N  = 8;
  localparam int NN = N * N;
`ifdef MATRIX_LOADER_ORDER_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT (n=8) ----------------
  logic        start, value_stb, value_ack, busy, full, done, err;
  logic [31:0] value, rd_data;
  logic [2:0]  i, j, rd_row, rd_col;
  logic [1:0]  state_o;

  matrix_loader #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value_stb(value_stb),
    .value(value), .i(i), .j(j), .value_ack(value_ack),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .busy(busy), .full(full), .done(done), .err(err), .state_o(state_o)
  );

  // ---------------- DUT (n=2) ----------------
  logic        start2, stb2, ack2, busy2, full2, done2, err2;
  logic [31:0] val2, rd_data2;
  logic        i2, j2, rd_row2, rd_col2;
  logic [1:0]  state2;

  matrix_loader #(.n(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .value_stb(stb2),
    .value(val2), .i(i2), .j(j2), .value_ack(ack2),
    .rd_row(rd_row2), .rd_col(rd_col2), .rd_data(rd_data2),
    .busy(busy2), .full(full2), .done(done2), .err(err2), .state_o(state2)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  logic rd_req = 1'b0;
  logic ack_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic pend;
    logic [31:0] e;
    pend = rd_req;
    cyc++;
    #1;
    if (pend) begin
      if (exp_q.size() == 0) begin
        chk("rd_queue_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
      end
    end
    if (value_ack) begin
      ack_cnt++;
      chk("ack_width", {31'd0, ack_prev}, 32'd0);
    end
    ack_prev = value_ack;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (done2) done2_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic read_exp(input int r, input int c, input logic [31:0] e);
    @(negedge clk);
    rd_row = 3'(r);
    rd_col = 3'(c);
    rd_req = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic readback_all(input logic [31:0] base);
    for (int k = 0; k < NN; k++) read_exp(k / N, k % N, base + 32'(k));
  endtask

  // Reader model. cont=1 keeps value_stb high across elements.
  task automatic stream(input logic [31:0] base, input bit cont, input int bad_idx,
                        input int start_at, input int rst_at);
    for (int k = 0; k < NN; k++) begin
      int w;
      bit got;
      if (!cont || k == 0) begin
        @(negedge clk);
        value_stb = 1'b1;
      end
      value = base + 32'(k);
      i = 3'(k / N);
      j = (k == bad_idx) ? 3'((k % N) + 1) : 3'(k % N);
      if (k == start_at) start = 1'b1;
      w = 0;
      got = 1'b0;
      while (!got && w < 20) begin
        @(posedge clk);
        #1;
        w++;
        if (value_ack) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
        chk("ack_timeout", 32'd0, 32'd1);
        value_stb = 1'b0;
        return;
      end
      if (cont && k > 0) chk("ack_gap", 32'(w), 32'd2);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {31'd0, value_ack}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        value_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!cont) begin
        value_stb = 1'b0;
        repeat (2) @(posedge clk);
      end
    end
    if (cont) begin
      value = 32'hBAD0_0000;
      repeat (10) @(posedge clk);
      value_stb = 1'b0;
    end
  endtask

  task automatic expect_complete(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_acks"}, 32'(ack_cnt), 32'(NN));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_full"}, {31'd0, full}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    start = 0; value_stb = 0; value = 0; i = 0; j = 0; rd_row = 0; rd_col = 0;
    start2 = 0; stb2 = 0; val2 = 0; i2 = 0; j2 = 0; rd_row2 = 0; rd_col2 = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_ack", {31'd0, value_ack}, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_state", {30'd0, state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: basic load of value = i*8 + j.
    ack_cnt = 0; done_cnt = 0;
    do_start();
    chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
    stream(32'd0, 1'b0, -1, -1, -1);
    expect_complete("t1");
    lat = done_cyc - start_cyc;
    checks++;
    if (lat < 3 * NN || lat > 3 * NN + 2) begin
      failures++;
      $display("FAIL t1_done_latency: got %0d expected %0d..%0d", lat, 3 * NN, 3 * NN + 2);
    end
    chk("t1_err", {31'd0, err}, 32'd0);
    read_exp(3, 5, 32'd29);
    readback_all(32'd0);

    // Test 2: continuous strobe; acks on alternate cycles, no capture after the load.
    ack_cnt = 0; done_cnt = 0;
    do_start();
    stream(32'h0000_1000, 1'b1, -1, -1, -1);
    expect_complete("t2");
    readback_all(32'h0000_1000);

    // Test 3: start mid-load ignored, then a second start reloads.
    ack_cnt = 0; done_cnt = 0;
    do_start();
    stream(32'h0000_3000, 1'b0, -1, 10, -1);
    expect_complete("t3a");
    read_exp(7, 7, 32'h0000_303F);
    ack_cnt = 0; done_cnt = 0;
    do_start();
    chk("t3_full_cleared", {31'd0, full}, 32'd0);
    stream(32'h5000_0000, 1'b0, -1, -1, -1);
    expect_complete("t3b");
    readback_all(32'h5000_0000);

    // Test 4: reset asserted while element 20 is being acknowledged.
    ack_cnt = 0; done_cnt = 0;
    do_start();
    stream(32'h000A_0000, 1'b0, -1, -1, 20);
    repeat (3) @(negedge clk);
    chk("t4_no_done", 32'(done_cnt), 32'd0);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    ack_cnt = 0; done_cnt = 0;
    do_start();
    stream(32'h000C_0000, 1'b0, -1, -1, -1);
    expect_complete("t4");
    readback_all(32'h000C_0000);

    // Test 5: reader presents j=2 while the loader expects column 1.
    ack_cnt = 0; done_cnt = 0;
    do_start();
    stream(32'h0000_7000, 1'b0, 1, -1, -1);
    expect_complete("t5");
    chk("t5_err", {31'd0, err}, {31'd0, ERR_EXP});
    read_exp(0, 1, 32'h0000_7001);
    read_exp(0, 2, 32'h0000_7002);
    ack_cnt = 0; done_cnt = 0;
    do_start();
    chk("t5_err_cleared", {31'd0, err}, 32'd0);
    stream(32'h0000_8000, 1'b0, -1, -1, -1);
    expect_complete("t5b");
    chk("t5b_err", {31'd0, err}, 32'd0);

    // Test 6: n=2 instance.
    done2_cnt = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int w;
      @(negedge clk);
      stb2 = 1'b1;
      val2 = 32'hDEAD_BEEF + 32'(k);
      i2 = 1'(k / 2);
      j2 = 1'(k % 2);
      w = 0;
      while (!ack2 && w < 20) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk("n2_ack_seen", {31'd0, ack2}, 32'd1);
      stb2 = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (3) @(negedge clk);
    chk("n2_done_cnt", 32'(done2_cnt), 32'd1);
    chk("n2_full", {31'd0, full2}, 32'd1);
    rd_row2 = 1'b1;
    rd_col2 = 1'b1;
    @(posedge clk);
    #1;
    chk("n2_rd_1_1", rd_data2, 32'hDEAD_BEF2);
    @(negedge clk);
    rd_row2 = 1'b0;
    rd_col2 = 1'b0;
    @(posedge clk);
    #1;
    chk("n2_rd_0_0", rd_data2, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
